// File: rtl/ldtu_ser_pkg.sv
// ldtu_ser_pkg
// Shared definitions for the serial lane word aligner slice.
//   WORD_W       : recovered word width in bits (32)
//   DEFAULT_IDLE : serializer idle word, used as the alignment marker
//   aligner_state_e : aligner FSM state encoding (HUNT, CHECK, LOCKED)
package ldtu_ser_pkg;

    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] DEFAULT_IDLE = 32'hEAAA_AAAA;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } aligner_state_e;

endpackage

// File: rtl/ser_shift_window.sv
// ser_shift_window
// Bit-serial shift register and idle-word comparator. The window includes
// the bit on serial_in this cycle, so a match is seen on the same edge
// that samples the last bit of the idle word.
// Ports:
//   clock      in  : bit-rate clock, rising edge
//   rst_b      in  : asynchronous active-low reset, clears the history
//   serial_in  in  : serial lane, MSB first
//   window     out : {history[30:0], serial_in}
//   idle_match out : window equals IDLE_PATTERN
module ser_shift_window
    import ldtu_ser_pkg::*;
#(
    parameter logic [WORD_W-1:0] IDLE_PATTERN = DEFAULT_IDLE
) (
    input  logic              clock,
    input  logic              rst_b,
    input  logic              serial_in,
    output logic [WORD_W-1:0] window,
    output logic              idle_match
);

    logic [WORD_W-1:0] shift_q;
    logic [WORD_W-1:0] shift_d;

    assign shift_d    = {shift_q[WORD_W-2:0], serial_in};
    assign window     = shift_d;
    assign idle_match = (shift_d == IDLE_PATTERN);

    // History register; cleared on reset so hunting restarts from an empty window.
    always_ff @(posedge clock or negedge rst_b) begin
        if (!rst_b) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/ser_word_aligner.sv
// ser_word_aligner
// Recovers 32-bit word boundaries from one serializer lane by hunting for
// the idle word, confirming LOCK_CNT boundary-aligned idles, then emitting
// every boundary word while locked.
// Parameters:
//   IDLE_PATTERN : alignment marker word
//   LOCK_CNT     : consecutive aligned idles needed for lock (1..15)
// Ports:
//   clock          in  : bit-rate clock, rising edge
//   rst_b          in  : asynchronous active-low reset
//   serial_in      in  : serial lane, MSB first
//   realign        in  : synchronous request to drop alignment and re-hunt
//   word_out       out : last recovered word (held between strobes)
//   word_valid     out : one-cycle strobe, word_out valid
//   locked         out : high while in LOCKED (registered)
//   align_fail_cnt out : saturating count of failed lock attempts
// Build option:
//   ALIGNER_IDLE_FILTER_EN : when defined, idle words seen at a LOCKED
//                            boundary are neither strobed nor loaded.
module ser_word_aligner
    import ldtu_ser_pkg::*;
#(
    parameter logic [WORD_W-1:0] IDLE_PATTERN = DEFAULT_IDLE,
    parameter int unsigned       LOCK_CNT     = 4
) (
    input  logic              clock,
    input  logic              rst_b,
    input  logic              serial_in,
    input  logic              realign,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    output logic              locked,
    output logic [7:0]        align_fail_cnt
);

    localparam logic [3:0] LOCK_TARGET = LOCK_CNT[3:0];

    logic [WORD_W-1:0] window;
    logic              idle_match;

    aligner_state_e    state_q;
    logic [4:0]        bit_cnt_q;
    logic [3:0]        good_cnt_q;
    logic [3:0]        good_cnt_inc;
    logic [WORD_W-1:0] word_out_q;
    logic              word_valid_q;
    logic              locked_q;
    logic [7:0]        fail_cnt_q;
    logic              boundary;

    ser_shift_window #(
        .IDLE_PATTERN(IDLE_PATTERN)
    ) u_window (
        .clock      (clock),
        .rst_b      (rst_b),
        .serial_in  (serial_in),
        .window     (window),
        .idle_match (idle_match)
    );

    // bit_cnt is cleared on the edge that matched the idle, so the next
    // full word completes when it reaches 31.
    assign boundary     = (bit_cnt_q == 5'd31);
    assign good_cnt_inc = good_cnt_q + 4'd1;

    // Alignment FSM with its counters and registered outputs. realign is
    // checked first so it overrides any coincident boundary action.
    always_ff @(posedge clock or negedge rst_b) begin
        if (!rst_b) begin
            state_q      <= HUNT;
            bit_cnt_q    <= '0;
            good_cnt_q   <= '0;
            word_out_q   <= '0;
            word_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            fail_cnt_q   <= '0;
        end else begin
            word_valid_q <= 1'b0;
            if (realign) begin
                state_q  <= HUNT;
                locked_q <= 1'b0;
            end else begin
                unique case (state_q)
                    HUNT: begin
                        if (idle_match) begin
                            bit_cnt_q  <= '0;
                            good_cnt_q <= 4'd1;
                            if (LOCK_TARGET == 4'd1) begin
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                            end else begin
                                state_q  <= CHECK;
                            end
                        end
                    end
                    CHECK: begin
                        bit_cnt_q <= bit_cnt_q + 5'd1;
                        if (boundary) begin
                            if (idle_match) begin
                                good_cnt_q <= good_cnt_inc;
                                if (good_cnt_inc == LOCK_TARGET) begin
                                    state_q  <= LOCKED;
                                    locked_q <= 1'b1;
                                end
                            end else begin
                                state_q <= HUNT;
                                if (fail_cnt_q != 8'hFF) begin
                                    fail_cnt_q <= fail_cnt_q + 8'd1;
                                end
                            end
                        end
                    end
                    LOCKED: begin
                        bit_cnt_q <= bit_cnt_q + 5'd1;
                        if (boundary) begin
`ifdef ALIGNER_IDLE_FILTER_EN
                            if (!idle_match) begin
                                word_out_q   <= window;
                                word_valid_q <= 1'b1;
                            end
`else
                            word_out_q   <= window;
                            word_valid_q <= 1'b1;
`endif
                        end
                    end
                    default: begin
                        state_q  <= HUNT;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign word_out       = word_out_q;
    assign word_valid     = word_valid_q;
    assign locked         = locked_q;
    assign align_fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_ser_word_aligner.sv
// tb_ser_word_aligner
// Self-checking bench for ser_word_aligner. Every bit is mirrored into a
// behavioural model that tracks alignment as "bits since the anchor idle"
// and predicts the registered outputs after each clock edge.
// Build option ALIGNER_IDLE_FILTER_EN selects the idle-filter expectations.
module tb_ser_word_aligner;

    localparam logic [31:0] IDLE  = 32'hEAAA_AAAA;
    localparam int          LOCKN = 4;
`ifdef ALIGNER_IDLE_FILTER_EN
    localparam bit FILTER_ON = 1'b1;
`else
    localparam bit FILTER_ON = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        rst_b = 1'b1;
    logic        serial_in = 1'b0;
    logic        realign = 1'b0;
    logic [31:0] word_out;
    logic        word_valid;
    logic        locked;
    logic [7:0]  align_fail_cnt;

    ser_word_aligner #(
        .IDLE_PATTERN(IDLE),
        .LOCK_CNT    (LOCKN)
    ) dut (
        .clock          (clock),
        .rst_b          (rst_b),
        .serial_in      (serial_in),
        .realign        (realign),
        .word_out       (word_out),
        .word_valid     (word_valid),
        .locked         (locked),
        .align_fail_cnt (align_fail_cnt)
    );

    // Free-running bit clock, 10 time units per bit.
    always #5 clock = ~clock;

    int checks     = 0;
    int failures   = 0;
    int validCount = 0;

    // Model: mPhase < 0 means hunting, otherwise bits received since the anchor.
    logic [31:0] mWin;
    int          mPhase;
    int          mGood;
    bit          mAligned;
    logic [31:0] eOut;
    bit          eValid;
    bit          eLocked;
    int          eFail;

    task automatic modelReset();
        mWin     = '0;
        mPhase   = -1;
        mGood    = 0;
        mAligned = 1'b0;
        eOut     = '0;
        eValid   = 1'b0;
        eLocked  = 1'b0;
        eFail    = 0;
    endtask

    task automatic modelStep(input bit b, input bit rl);
        mWin   = {mWin[30:0], b};
        eValid = 1'b0;
        if (rl) begin
            mPhase   = -1;
            mAligned = 1'b0;
        end else if (mPhase < 0) begin
            if (mWin == IDLE) begin
                mPhase   = 0;
                mGood    = 1;
                mAligned = (LOCKN == 1);
            end
        end else begin
            mPhase = mPhase + 1;
            if (mPhase == 32) begin
                mPhase = 0;
                if (mAligned) begin
                    if (!(FILTER_ON && mWin == IDLE)) begin
                        eValid = 1'b1;
                        eOut   = mWin;
                    end
                end else if (mWin == IDLE) begin
                    mGood = mGood + 1;
                    if (mGood == LOCKN) mAligned = 1'b1;
                end else begin
                    mPhase = -1;
                    if (eFail < 255) eFail = eFail + 1;
                end
            end
        end
        eLocked = mAligned && (mPhase >= 0);
    endtask

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, ".word_valid"}, {31'b0, word_valid}, {31'b0, eValid});
        checkValue({tag, ".locked"}, {31'b0, locked}, {31'b0, eLocked});
        checkValue({tag, ".word_out"}, word_out, eOut);
        checkValue({tag, ".align_fail_cnt"}, {24'b0, align_fail_cnt}, eFail[31:0]);
    endtask

    // Drive one bit at the falling edge, then check just after the rising edge.
    task automatic applyStimulus(input bit b, input bit rl);
        @(negedge clock);
        serial_in = b;
        realign   = rl;
        modelStep(b, rl);
        @(posedge clock);
        #1;
        if (word_valid) validCount++;
        checkOutput("cycle");
    endtask

    task automatic sendWord(input logic [31:0] w, input bit realignOnLast);
        for (int i = 31; i >= 0; i--) begin
            applyStimulus(w[i], (i == 0) && realignOnLast);
        end
    endtask

    // Assert reset now, confirm outputs clear without a clock edge, then release.
    task automatic resetDut();
        rst_b = 1'b0;
        #1;
        serial_in = 1'b0;
        realign   = 1'b0;
        modelReset();
        checkOutput("async_reset");
        repeat (2) @(posedge clock);
        @(negedge clock);
        rst_b = 1'b1;
        @(posedge clock);
        #1;
    endtask

    logic [31:0] w;
    logic [7:0]  failSnapshot;

    initial begin
        #2;
        resetDut();

        // Scenario 1: five idles at bit offset 7, then a data word.
        for (int i = 0; i < 7; i++) applyStimulus(1'($urandom_range(0, 1)), 1'b0);
        validCount = 0;
        for (int i = 1; i <= 5; i++) begin
            sendWord(IDLE, 1'b0);
            if (i == 3) checkValue("s1_unlocked_after_idle3", {31'b0, locked}, 32'd0);
            if (i == 4) checkValue("s1_locked_after_idle4", {31'b0, locked}, 32'd1);
        end
        sendWord(32'h1234_5678, 1'b0);
        checkValue("s1_valid_pulses", validCount, FILTER_ON ? 32'd1 : 32'd2);
        checkValue("s1_last_word", word_out, 32'h1234_5678);

        // Scenario 2: idle, idle, zero word at the boundary fails the check.
        applyStimulus(1'b0, 1'b1);
        sendWord(IDLE, 1'b0);
        sendWord(IDLE, 1'b0);
        sendWord(32'h0000_0000, 1'b0);
        checkValue("s2_fail_cnt", {24'b0, align_fail_cnt}, 32'd1);
        checkValue("s2_not_locked", {31'b0, locked}, 32'd0);

        // Scenario 3: realign on a locked boundary, then relock.
        for (int i = 0; i < 4; i++) sendWord(IDLE, 1'b0);
        sendWord($urandom, 1'b0);
        failSnapshot = align_fail_cnt;
        sendWord(32'hCAFE_F00D, 1'b1);
        checkValue("s3_no_valid_on_realign", {31'b0, word_valid}, 32'd0);
        checkValue("s3_unlocked", {31'b0, locked}, 32'd0);
        checkValue("s3_fail_unchanged", {24'b0, align_fail_cnt}, {24'b0, failSnapshot});
        for (int i = 0; i < 4; i++) sendWord(IDLE, 1'b0);
        checkValue("s3_relocked", {31'b0, locked}, 32'd1);

        // Random traffic with occasional idles and rare realign requests.
        for (int n = 0; n < 40; n++) begin
            w = ($urandom_range(0, 3) == 0) ? IDLE : $urandom;
            for (int i = 31; i >= 0; i--) begin
                applyStimulus(w[i], ($urandom_range(0, 499) == 0));
            end
        end

        // Scenario 4: 300 forced CHECK failures saturate the counter.
        applyStimulus(1'b0, 1'b1);
        for (int n = 0; n < 300; n++) begin
            sendWord(IDLE, 1'b0);
            sendWord(32'h0000_0000, 1'b0);
        end
        checkValue("s4_fail_saturated", {24'b0, align_fail_cnt}, 32'd255);

        // Scenario 5: reset mid-word while locked, then relock.
        for (int i = 0; i < 4; i++) sendWord(IDLE, 1'b0);
        checkValue("s5_locked_before_reset", {31'b0, locked}, 32'd1);
        w = 32'h0F0F_3C3C;
        for (int i = 31; i >= 15; i--) applyStimulus(w[i], 1'b0);
        #2;
        resetDut();
        checkValue("s5_fail_cleared", {24'b0, align_fail_cnt}, 32'd0);
        for (int i = 0; i < 4; i++) sendWord(IDLE, 1'b0);
        checkValue("s5_relocked", {31'b0, locked}, 32'd1);

        // Scenario 6: idle, data, idle on a locked stream.
        validCount = 0;
        sendWord(IDLE, 1'b0);
        sendWord(32'hA5A5_A5A5, 1'b0);
        sendWord(IDLE, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkValue("s6_valid_pulses", validCount, FILTER_ON ? 32'd1 : 32'd3);
        checkValue("s6_word_out", word_out, FILTER_ON ? 32'hA5A5_A5A5 : IDLE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ser_word_aligner.md
SER_WORD_ALIGNER -- requirements
Module: ser_word_aligner

Interface
REQ-001 Parameter IDLE_PATTERN, default 32'hEAAAAAAA: serializer idle word used as the alignment marker.
REQ-002 Parameter LOCK_CNT, default 4: consecutive boundary-aligned idle words required for lock; legal range 1..15.
REQ-003 clock  input  1: single bit-rate clock, same as the serializer clock; all logic is on its rising edge.
REQ-004 rst_b  input  1: reset, asynchronous assert, active-low.
REQ-005 serial_in  input  1: one serializer lane output, MSB first.
REQ-006 realign  input  1: synchronous request to drop alignment and re-hunt.
REQ-007 word_out  output  32: last recovered word.
REQ-008 word_valid  output  1: one-cycle strobe; word_out is valid when high.
REQ-009 locked  output  1: high while in LOCKED.
REQ-010 align_fail_cnt  output  8: saturating count of failed lock attempts.

Function
REQ-011 Every cycle, a 32-bit shift register shall update to window = {shift_reg[30:0], serial_in}.
REQ-012 The FSM shall have exactly three states: HUNT, CHECK, LOCKED.
REQ-013 HUNT: compare window with IDLE_PATTERN every cycle; on match, clear bit_cnt to 0, set good_cnt to 1, and go to CHECK, or directly to LOCKED if LOCK_CNT==1.
REQ-014 CHECK/LOCKED: bit_cnt shall be 5 bits, increment every cycle, and wrap 31->0; the boundary is the cycle with bit_cnt==31.
REQ-015 CHECK boundary, window==IDLE_PATTERN: increment good_cnt; go to LOCKED when the incremented value equals LOCK_CNT.
REQ-016 CHECK boundary, window!=IDLE_PATTERN: return to HUNT and increment align_fail_cnt, saturating at 255.
REQ-017 LOCKED boundary: register word_out<=window and assert word_valid for exactly one cycle; latency is one clock after the edge sampling the word's last bit.
REQ-018 The idle word that completes lock shall not be emitted; the first emitted word is the next full 32-bit boundary.
REQ-019 word_valid shall be low outside LOCKED and on all non-boundary cycles; word_out shall hold its value between strobes.
REQ-020 locked shall be registered, high from the cycle after entering LOCKED until the cycle after leaving it.
REQ-021 realign in any state: next state HUNT, word_valid low, locked low, and align_fail_cnt unchanged; realign takes priority over a coincident boundary event.
REQ-022 LOCKED shall not exit on data content; it exits only on realign or reset.

Reset
REQ-023 rst_b low shall immediately clear shift_reg, bit_cnt, good_cnt, word_out, word_valid, locked and align_fail_cnt to 0, and set the state to HUNT.
REQ-024 Reset asserted mid-word or mid-CHECK shall discard partial progress; after release, hunting restarts from an empty window.

Configuration
REQ-025 The macro ALIGNER_IDLE_FILTER_EN, when defined, shall suppress word_valid for LOCKED boundary words equal to IDLE_PATTERN; word_out shall still not update for those words.
REQ-026 When ALIGNER_IDLE_FILTER_EN is not defined, every LOCKED boundary word, including idle words, shall be emitted with word_valid.

Structure
REQ-027 The shared package ldtu_ser_pkg shall hold the word width constant (32), the default idle pattern, and the aligner state encoding.
REQ-028 The sub-module ser_shift_window shall contain the shift register and idle comparator, with outputs window and idle_match; the FSM and counters shall stay in ser_word_aligner.

Verification
REQ-029 Scenario 1: 5 idle words at bit offset 7, then 32'h12345678 -> locked rises after the 4th idle, and in filter-off builds word_valid pulses once each for idle #5 and 32'h12345678.
REQ-030 Scenario 2: idle, idle, then 32'h00000000 at the boundary -> back to HUNT, align_fail_cnt=1, locked stays 0.
REQ-031 Scenario 3: locked stream, realign pulsed on a boundary cycle -> no word_valid that cycle, locked=0 next cycle, and relock after 4 further idles.
REQ-032 Scenario 4: 300 forced CHECK failures -> align_fail_cnt saturates at 255.
REQ-033 Scenario 5: rst_b dropped mid-word while LOCKED -> all outputs 0 asynchronously; after release, 4 idles relock.
REQ-034 Scenario 6 (ALIGNER_IDLE_FILTER_EN defined): locked stream idle, 32'hA5A5A5A5, idle -> exactly one word_valid, with word_out=32'hA5A5A5A5.
